// File: rtl/trim_cal_pkg.sv
// Shared types and default constants for the regulator trim calibrator.
package trim_cal_pkg;

   localparam int               DEF_TRIM_W        = 4;
   localparam int               DEF_SETTLE_CYCLES = 16;
   localparam logic [3:0]       DEF_TRIM_RESET    = 4'b1000;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DECIDE,
      DONE
   } calState_e;

   // Width of a down-counter that must hold SETTLE_CYCLES-1.
   function automatic int settleCntWidth(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Shift the raw input through two flops so metastability resolves before use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/trim_calibrator.sv
// Successive-approximation controller that searches the regulator trim code
// placing vout at the largest code not above target, one trim bit per step.
module trim_calibrator
   import trim_cal_pkg::*;
#(
   parameter int                TRIM_W        = DEF_TRIM_W,
   parameter int                SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter logic [TRIM_W-1:0] TRIM_RESET    = DEF_TRIM_RESET
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cmp_high,
   output logic [TRIM_W-1:0] trim,
   output logic              busy,
   output logic              done,
   output logic              saturated
);

   localparam int                IDX_W    = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
   localparam int                CNT_W    = settleCntWidth(SETTLE_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(TRIM_W - 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [TRIM_W-1:0] TRIM_MSB = {1'b1, {(TRIM_W-1){1'b0}}};

   calState_e         state_q;
   logic [TRIM_W-1:0] trim_q;
   logic [IDX_W-1:0]  bitIdx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              saturated_q;

   logic              cmpS;
   logic [IDX_W-1:0]  bitIdx_d;
   logic [TRIM_W-1:0] decidedTrim_d;
   logic [TRIM_W-1:0] nextTrial_d;

   sync_2ff u_cmpSync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (cmp_high),
      .q_o   (cmpS)
   );

   // Resolve the bit under test from the comparator and form the next trial code.
   always_comb begin
      bitIdx_d      = bitIdx_q - IDX_W'(1);
      decidedTrim_d = trim_q;
      if (cmpS) begin
         decidedTrim_d[bitIdx_q] = 1'b0;
      end
      nextTrial_d   = decidedTrim_d | (TRIM_W'(1) << bitIdx_d);
   end

   // Search FSM: settle each trial for SETTLE_CYCLES, then commit one bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         trim_q      <= TRIM_RESET;
         bitIdx_q    <= IDX_MSB;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         saturated_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  trim_q      <= TRIM_MSB;
                  bitIdx_q    <= IDX_MSB;
                  cnt_q       <= CNT_LOAD;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  saturated_q <= 1'b0;
                  state_q     <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= DECIDE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DECIDE: begin
               if (bitIdx_q == '0) begin
                  trim_q      <= decidedTrim_d;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  saturated_q <= (decidedTrim_d == '0) || (&decidedTrim_d);
                  state_q     <= DONE;
               end else begin
                  trim_q   <= nextTrial_d;
                  bitIdx_q <= bitIdx_d;
                  cnt_q    <= CNT_LOAD;
                  state_q  <= SETTLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign trim      = trim_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign saturated = saturated_q;

endmodule
